// File: rtl/pipe_pkg.sv
// Shared defaults and the {PC, instruction} entry type for the fetch-to-decode prefetch buffer.
package pipe_pkg;

    localparam int DEF_DEPTH = 4;
    localparam int DEF_AW    = 64;
    localparam int DEF_IW    = 32;

    typedef struct packed {
        logic [DEF_AW-1:0] pc;
        logic [DEF_IW-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/prefetch_buffer_if.sv
// Fetch-side and decode-side handshake bundle of the prefetch buffer.
interface prefetch_buffer_if
    import pipe_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int IW = DEF_IW
);

    logic [AW-1:0] imem_addr_F;
    logic [IW-1:0] imem_data_F;
    logic          valid_F;
    logic          ready_F;
    logic          flush;
    logic [AW-1:0] pc_D;
    logic [IW-1:0] instr_D;
    logic          valid_D;
    logic          ready_D;

    // master = fetch/decode pipeline around the buffer, slave = the buffer itself
    modport master (
        output imem_addr_F, imem_data_F, valid_F, flush, ready_D,
        input  ready_F, pc_D, instr_D, valid_D
    );

    modport slave (
        input  imem_addr_F, imem_data_F, valid_F, flush, ready_D,
        output ready_F, pc_D, instr_D, valid_D
    );

endinterface

// File: rtl/fifo_ctrl.sv
// Pointer/occupancy bookkeeping for the prefetch buffer: handshake qualification and flush.
module fifo_ctrl
    import pipe_pkg::*;
#(
    parameter  int DEPTH = DEF_DEPTH,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_valid_F,
    input  logic          i_ready_D,
    input  logic          i_flush,
    output logic          o_ready_F,
    output logic          o_valid_D,
    output logic          o_push,
    output logic [PW-1:0] o_wr_ptr,
    output logic [PW-1:0] o_rd_ptr
);

    localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    logic [PW:0]   r_count;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic          w_ready;
    logic          w_valid;
    logic          w_push;
    logic          w_pop;

    // ready depends on count alone, so a full buffer never accepts even while popping
    assign w_ready = (r_count < CNT_FULL);
    assign w_valid = (r_count != '0);
    assign w_push  = i_valid_F & w_ready & ~i_flush;
    assign w_pop   = w_valid & i_ready_D & ~i_flush;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_ready_F = w_ready;
    assign o_valid_D = w_valid;
    assign o_push    = w_push;
    assign o_wr_ptr  = r_wr_ptr;
    assign o_rd_ptr  = r_rd_ptr;

endmodule

// File: rtl/prefetch_buffer.sv
// Small FIFO of {PC, instruction} pairs decoupling instruction fetch from decode.
module prefetch_buffer
    import pipe_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = DEF_AW,
    parameter int IW    = DEF_IW
) (
    input  logic             i_clk,
    input  logic             i_reset,
    prefetch_buffer_if.slave bus
);

    localparam int PW = $clog2(DEPTH);

    logic             w_push;
    logic [PW-1:0]    w_wr_ptr;
    logic [PW-1:0]    w_rd_ptr;
    logic [DEPTH-1:0] w_we;
    logic [AW-1:0]    r_pc    [DEPTH];
    logic [IW-1:0]    r_instr [DEPTH];

    fifo_ctrl #(.DEPTH(DEPTH)) u_ctrl (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_valid_F (bus.valid_F),
        .i_ready_D (bus.ready_D),
        .i_flush   (bus.flush),
        .o_ready_F (bus.ready_F),
        .o_valid_D (bus.valid_D),
        .o_push    (w_push),
        .o_wr_ptr  (w_wr_ptr),
        .o_rd_ptr  (w_rd_ptr)
    );

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
        assign w_we[gi] = w_push && (w_wr_ptr == PW'(gi));
    end

    // Storage is only cleared by reset; flush just rewinds the pointers.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pc[i]    <= '0;
                r_instr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_we[i]) begin
                    r_pc[i]    <= bus.imem_addr_F;
                    r_instr[i] <= bus.imem_data_F;
                end
            end
        end
    end

    assign bus.pc_D    = r_pc[w_rd_ptr];
    assign bus.instr_D = r_instr[w_rd_ptr];

endmodule

// File: doc/prefetch_buffer.md
PREFETCH_BUFFER -- requirements
Module: prefetch_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered {PC, instruction} entries (power of two, >= 2).
REQ-002 Parameter AW, default 64, PC width.
REQ-003 Parameter IW, default 32, instruction width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 imem_addr_F  input  AW  PC of the instruction offered by fetch.
REQ-007 imem_data_F  input  IW  instruction word read from imem at imem_addr_F.
REQ-008 valid_F  input  1  fetch offers an entry this cycle.
REQ-009 ready_F  output  1  buffer accepts an entry this cycle; fetch holds its PC when low.
REQ-010 flush  input  1  taken branch (PCSrc); discards all buffered and offered entries.
REQ-011 pc_D  output  AW  PC of head entry.
REQ-012 instr_D  output  IW  instruction of head entry.
REQ-013 valid_D  output  1  head entry valid.
REQ-014 ready_D  input  1  decode consumes head entry this cycle.

Function
REQ-015 Push occurs when valid_F && ready_F && !flush; entry written at write pointer.
REQ-016 Pop occurs when valid_D && ready_D && !flush; read pointer advances.
REQ-017 ready_F = (count < DEPTH), combinational from count only; no push-through when full, even with simultaneous pop.
REQ-018 valid_D = (count != 0); pc_D/instr_D driven combinationally from entry at read pointer.
REQ-019 Latency: pushed entry appears at pc_D/instr_D with valid_D high on the cycle after the push edge; no empty-bypass.
REQ-020 Simultaneous push and pop (count between 1 and DEPTH-1): count unchanged, both pointers advance.
REQ-021 Pointers are log2(DEPTH) bits and wrap from DEPTH-1 to 0 with no gap.
REQ-022 Count is log2(DEPTH)+1 bits, range 0..DEPTH; never overflows or underflows.
REQ-023 Flush: on the edge where flush=1, count and both pointers become 0; push and pop that cycle are suppressed; valid_D low next cycle; ready_F high next cycle.
REQ-024 Flush while empty is a no-op apart from pointer reset.
REQ-025 Entry order is strictly FIFO; pc_D sequence equals accepted imem_addr_F sequence.
REQ-026 Entry storage is not cleared by flush; only valid accounting changes.

Reset
REQ-027 While reset=0: count=0, pointers=0, all entries zero; valid_D=0, ready_F=1, pc_D=0, instr_D=0, asynchronously.
REQ-028 Reset asserted mid-operation discards all entries; first push after release lands at entry 0.
REQ-029 Release of reset takes effect on next rising edge; no push accepted on an edge where reset=0.

Structure
REQ-030 Shared package pipe_pkg holds DEPTH, AW, IW defaults and typedef fetch_entry_t {pc, instr}.
REQ-031 Sub-module fifo_ctrl holds pointers, count, push/pop/flush qualification and ready_F/valid_D; prefetch_buffer holds entry array and output mux.

Verification
REQ-032 Reset low 48 ns then high; push PCs 0,4,8,12 with ready_D=0 -> ready_F low after 4th push; valid_D=1, pc_D=0.
REQ-033 From full, ready_D=1, valid_F=1 for 4 cycles -> pc_D 0,4,8,12 in order; no push while full; ready_F returns high after first pop.
REQ-034 Continuous push/pop, PCs 0..36 step 4 -> pc_D reproduces sequence one cycle late, pointers wrap twice, count stays 1.
REQ-035 Buffer holding 16,20,24; flush=1 with valid_F=1, PC=28 -> next cycle valid_D=0, count=0; next push PC=0 appears as pc_D=0.
REQ-036 Reset low mid-stream with 3 entries -> valid_D=0, ready_F=1 immediately (before next edge); after release push PC=40 -> pc_D=40.
REQ-037 Push instr 32'hF8000000 at PC 8 on empty buffer -> instr_D=32'hF8000000, pc_D=8 one cycle later, not same cycle.
